// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mul_pkg;

  // Controller states; the value is visible on the top-level debug port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Bit positions inside the 4-bit flags word {N, Z, C, V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: optional add/subtract of the multiplicand into
// the accumulator, then an arithmetic right shift of {acc, q, q-1}.
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] acc_i,
  input  logic [WIDTH:0] q_i,
  input  logic           qm1_i,
  input  logic [WIDTH:0] mcand_i,
  output logic [WIDTH:0] acc_o,
  output logic [WIDTH:0] q_o,
  output logic           qm1_o
);

  logic           do_add;
  logic           do_sub;
  logic [WIDTH:0] operand;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] acc_sel;

  // A single adder handles both directions: subtraction is add of ~M plus 1.
  always_comb begin
    do_add  = ~q_i[0] & qm1_i;
    do_sub  = q_i[0] & ~qm1_i;
    operand = do_sub ? ~mcand_i : mcand_i;
    sum     = acc_i + operand + {{WIDTH{1'b0}}, do_sub};
    acc_sel = (do_add | do_sub) ? sum : acc_i;
    acc_o   = {acc_sel[WIDTH], acc_sel[WIDTH:1]};
    q_o     = {acc_sel[0], q_i[WIDTH:1]};
    qm1_o   = q_i[0];
  end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier, signed or unsigned, one iteration per
// clock. Operands are widened by one bit so both modes share the same signed
// datapath; WIDTH+1 iterations later the 2*WIDTH product and flags are latched.
//
// Handshake: start is sampled only in IDLE or DONE; the operation accepted on
// that edge completes with a one-cycle done pulse WIDTH+1 edges later, busy is
// high in between and every input is ignored while busy. A start seen during
// the DONE cycle launches the next operation with no gap.
module seq_booth_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [3:0]       flags,
  output mul_state_e       dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] ITERS = CW'(WIDTH + 1);

  mul_state_e       state_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH:0]   q_q;
  logic             qm1_q;
  logic [WIDTH:0]   mcand_q;
  logic             mode_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [3:0]       flags_q;

  logic [WIDTH:0]     step_acc;
  logic [WIDTH:0]     step_q;
  logic               step_qm1;
  logic [WIDTH:0]     mcand_d;
  logic [WIDTH:0]     mplier_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [3:0]         flags_d;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .q_i     (q_q),
    .qm1_i   (qm1_q),
    .mcand_i (mcand_q),
    .acc_o   (step_acc),
    .q_o     (step_q),
    .qm1_o   (step_qm1)
  );

  // Operand widening and the result/flags that the final iteration produces.
  always_comb begin
    mcand_d  = signed_mode ? {in1[WIDTH-1], in1} : {1'b0, in1};
    mplier_d = signed_mode ? {in2[WIDTH-1], in2} : {1'b0, in2};
    prod_d   = {step_acc[WIDTH-2:0], step_q};
    flags_d  = 4'b0000;
    flags_d[FLAG_N] = mode_q & prod_d[2*WIDTH-1];
    flags_d[FLAG_Z] = (prod_d == '0);
    flags_d[FLAG_C] = ~mode_q & (prod_d[2*WIDTH-1:WIDTH] != '0);
    flags_d[FLAG_V] = mode_q &
                      (prod_d[2*WIDTH-1:WIDTH] != {WIDTH{prod_d[WIDTH-1]}});
  end

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      flags_q <= 4'b0000;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            acc_q   <= '0;
            q_q     <= mplier_d;
            qm1_q   <= 1'b0;
            mcand_q <= mcand_d;
            mode_q  <= signed_mode;
            cnt_q   <= ITERS;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= step_acc;
          q_q   <= step_q;
          qm1_q <= step_qm1;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= prod_d[2*WIDTH-1:WIDTH];
            lo_q    <= prod_d[WIDTH-1:0];
            flags_q <= flags_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign product_hi  = hi_q;
  assign product_lo  = lo_q;
  assign flags       = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Self-checking bench for seq_booth_multiplier at WIDTH=32: directed corner
// products, randomized operations against an arithmetic reference model,
// busy-time input abuse, back-to-back starts and a mid-run reset.
module tb_seq_booth_multiplier;
  import mul_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         busy;
  logic         done;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;
  logic [3:0]   flags;
  mul_state_e   dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Expected {hi, lo, flags} and the cycle at which each start was accepted.
  logic [2*W+3:0] exp_q[$];
  int             acc_cyc_q[$];

  seq_booth_multiplier #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .in1         (in1),
    .in2         (in2),
    .busy        (busy),
    .done        (done),
    .product_hi  (product_hi),
    .product_lo  (product_lo),
    .flags       (flags),
    .dbg_state_o (dbg_state)
  );

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain full-width arithmetic plus the flag rules.
  function automatic logic [2*W+3:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic sm);
    logic [2*W-1:0] p;
    logic [3:0]     f;
    longint         sa;
    longint         sb;
    if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    f[3] = sm & p[2*W-1];
    f[2] = (p == '0);
    f[1] = !sm && (p[2*W-1:W] != '0);
    f[0] = sm && (p[2*W-1:W] != {W{p[W-1]}});
    return {p, f};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Driver: present operands at a negedge, hold start across one posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sm, input logic [2*W+3:0] exp);
    in1 = a;
    in2 = b;
    signed_mode = sm;
    start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    acc_cyc_q.push_back(cyc);
    start = 1'b0;
  endtask

  // Waits (bounded) until done is seen at a negedge.
  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 60);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles, expected within %0d", n, LAT);
    end
  endtask

  // Monitor: pop and compare every time the DUT presents a result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0 || acc_cyc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done at cycle %0d, expected no result", cyc);
      end else begin
        logic [2*W+3:0] e;
        int             c0;
        e  = exp_q.pop_front();
        c0 = acc_cyc_q.pop_front();
        check("product_hi", 64'(product_hi), 64'(e[2*W+3:W+4]));
        check("product_lo", 64'(product_lo), 64'(e[W+3:4]));
        check("flags", 64'(flags), 64'(e[3:0]));
        check("latency", 64'(cyc - c0), 64'(LAT));
      end
    end
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sm;
    rst_n = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    in1 = '0;
    in2 = '0;

    // Reset state.
    #1 rst_n = 1'b0;
    #2;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_hi", 64'(product_hi), 64'(0));
    check("reset_lo", 64'(product_lo), 64'(0));
    check("reset_flags", 64'(flags), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases with hand-computed expectations.
    issue(32'd7, 32'd6, 1'b0, {32'h0000_0000, 32'h0000_002A, 4'b0000});
    wait_done();
    @(negedge clk);
    issue(32'hFFFF_FFFD, 32'd5, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFF1, 4'b1000});
    wait_done();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'hFFFF_FFFE, 32'h0000_0001, 4'b0010});
    wait_done();
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, {32'h4000_0000, 32'h0000_0000, 4'b0001});
    wait_done();
    @(negedge clk);
    issue(32'h0, 32'h1234_5678, 1'b0, {32'h0, 32'h0, 4'b0100});
    wait_done();
    issue(32'h0, 32'h1234_5678, 1'b1, {32'h0, 32'h0, 4'b0100});
    wait_done();
    @(negedge clk);

    // Inputs and start toggled while busy must not disturb the operation.
    issue(32'h1357_9BDF, 32'hFEDC_BA98, 1'b1, model(32'h1357_9BDF, 32'hFEDC_BA98, 1'b1));
    repeat (4) @(negedge clk);
    check("busy_in_run", 64'(busy), 64'(1));
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      in1 = $urandom();
      in2 = $urandom();
      signed_mode = $urandom_range(0, 1);
      @(negedge clk);
    end
    start = 1'b0;
    wait_done();
    // Start during DONE: back-to-back operation.
    issue(32'd123456, 32'd654321, 1'b0, model(32'd123456, 32'd654321, 1'b0));
    wait_done();

    // Randomized operations with random gaps (gap 0 means back-to-back).
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 15);
        default: a = $urandom();
      endcase
      b  = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom();
      sm = $urandom_range(0, 1);
      issue(a, b, sm, model(a, b, sm));
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Reset in the middle of RUN, then a fresh operation.
    issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 64'h0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'(0));
    check("midreset_done", 64'(done), 64'(0));
    check("midreset_hi", 64'(product_hi), 64'(0));
    check("midreset_lo", 64'(product_lo), 64'(0));
    check("midreset_flags", 64'(flags), 64'(0));
    check("midreset_state", 64'(dbg_state), 64'(IDLE));
    exp_q.delete();
    acc_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1));
    wait_done();
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_booth_multiplier.md
SEQ_BOOTH_MULTIPLIER -- requirements
Module: seq_booth_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width (legal values: 4..64, even).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE or DONE.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-006 SHALL have ports in1, in2  input  WIDTH  multiplicand and multiplier; captured with start.
REQ-007 SHALL have port busy  output  1  high while in RUN.
REQ-008 SHALL have port done  output  1  high in DONE only (one-cycle pulse).
REQ-009 SHALL have ports product_hi, product_lo  output  WIDTH each  upper and lower halves of the 2*WIDTH product.
REQ-010 SHALL have port flags  output  4  {N, Z, C, V}, MSB first.

Function
REQ-011 SHALL use FSM states IDLE, RUN and DONE, with transitions IDLE->RUN on start, RUN->DONE after the last iteration, DONE->RUN on start, and DONE->IDLE otherwise.
REQ-012 On an accepted start, SHALL register the operands extended to WIDTH+1 bits (sign-extended if signed_mode, zero-extended otherwise), clear the accumulator, and load the iteration counter with WIDTH+1.
REQ-013 In RUN, SHALL perform one radix-2 Booth iteration per cycle: examine the multiplier bit pair {q0, q-1}; 01 adds the multiplicand, 10 subtracts it, 00/11 makes no change; then arithmetic-shift the {acc, q, q-1} register right by one.
REQ-014 SHALL assert done exactly WIDTH+1 rising edges after the edge that accepted start (33 for WIDTH=32); busy SHALL be high for the WIDTH+1 cycles in between.
REQ-015 SHALL register product_hi, product_lo and flags on entry to DONE and hold them unchanged until the next DONE.
REQ-016 SHALL set flag N = product[2W-1] when signed_mode, and N = 0 when unsigned.
REQ-017 SHALL set flag Z = 1 iff the full 2*WIDTH product is zero.
REQ-018 SHALL set flag C = 1 iff unsigned mode and product_hi is nonzero (result does not fit in WIDTH bits); C SHALL be 0 in signed mode.
REQ-019 SHALL set flag V = 1 iff signed mode and product_hi is not the sign extension of product_lo[W-1]; V SHALL be 0 in unsigned mode.
REQ-020 SHALL ignore start, in1, in2 and signed_mode while busy, leaving the operation in flight unaffected.
REQ-021 SHALL accept a start asserted during the DONE cycle, giving back-to-back operations with no idle gap.

Reset
REQ-022 SHALL, on rst_n low and regardless of state (including mid-RUN), immediately force state to IDLE, busy and done to 0, product_hi, product_lo and flags to 0, and all internal registers to 0.
REQ-023 SHALL ignore start in the first rising edge after rst_n deasserts only if start is low; no other reset-exit restriction applies.

Structure
REQ-024 SHALL take the FSM state enum (IDLE/RUN/DONE) and the flag bit indices (N=3, Z=2, C=1, V=0) from shared package mul_pkg.
REQ-025 SHALL implement a single iteration (add/sub/none plus the arithmetic shift) as the combinational sub-module booth_step, parametrised by WIDTH.
REQ-026 SHALL use exactly one (WIDTH+1)-bit adder/subtractor; no array multiplier.

Verification (WIDTH=32)
REQ-027 SHALL check: unsigned 7 x 6 -> hi=0x00000000, lo=0x0000002A, flags=0000, with done at edge 33.
REQ-028 SHALL check: signed -3 (0xFFFFFFFD) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, N=1, Z=0, C=0, V=0.
REQ-029 SHALL check: unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, C=1; and signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000, V=1, N=0.
REQ-030 SHALL check: 0 x 0x12345678 in either mode -> product 0, Z=1.
REQ-031 SHALL check: a second start plus operand changes while busy -> ignored, first result intact; start in DONE -> new result 33 edges later.
REQ-032 SHALL check: rst_n low at iteration 10 -> all outputs 0 at once and state IDLE; a fresh start then completes correctly.
